// File: rtl/uart_dec_sender.sv
// Binary-to-decimal ASCII sender: converts a latched value with double dabble,
// skips leading zeros, then streams digits (and optionally CR LF) to a uart.
module uart_dec_sender #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIGITS      = 5,
    parameter bit          APPEND_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             transmit,
    output logic [7:0]       tx_byte,
    input  logic             is_transmitting
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned PtrW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;

    typedef enum logic [2:0] {
        StIdle, StConv, StSkip, StLoad, StWait, StSend, StNext, StFin
    } state_e;

    // Which part of the string is currently being sent.
    typedef enum logic [1:0] {PhDigit, PhCr, PhLf} phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [PtrW-1:0]   ptr_q, ptr_d, msd, ptr_dec;
    logic [7:0]        byte_q, byte_d;

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Index of the most significant nonzero digit; 0 when the value is zero.
    always_comb begin
        msd = '0;
        for (int unsigned i = 1; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = PtrW'(i);
            end
        end
    end

    assign ptr_dec = ptr_q - 1'b1;

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    phase_d = PhDigit;
                    state_d = StConv;
                end
            end
            StConv: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StSkip;
                end
            end
            StSkip: begin
                // Byte is prepared here so it is already valid during LOAD.
                ptr_d   = msd;
                byte_d  = 8'h30 + {4'h0, bcd_q[4*msd +: 4]};
                state_d = StLoad;
            end
            StLoad: state_d = StWait;
            StWait: begin
                if (is_transmitting) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!is_transmitting) begin
                    state_d = StNext;
                end
            end
            StNext: begin
                if (phase_q == PhDigit && ptr_q != '0) begin
                    ptr_d   = ptr_dec;
                    byte_d  = 8'h30 + {4'h0, bcd_q[4*ptr_dec +: 4]};
                    state_d = StLoad;
                end else if (phase_q == PhDigit && APPEND_CRLF) begin
                    phase_d = PhCr;
                    byte_d  = 8'h0D;
                    state_d = StLoad;
                end else if (phase_q == PhCr) begin
                    phase_d = PhLf;
                    byte_d  = 8'h0A;
                    state_d = StLoad;
                end else begin
                    state_d = StFin;
                end
            end
            StFin: begin
                byte_d  = 8'h00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            phase_q <= PhDigit;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            byte_q  <= byte_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
    assign transmit = (state_q == StLoad);
    assign tx_byte  = byte_q;

endmodule

// File: doc/uart_dec_sender.md
Name: uart_dec_sender

Overview:
Transmit-side counterpart of the console's decimal key-in parser. Latches an unsigned binary value and converts it to decimal with shift-add-3 (double dabble). Suppresses leading zeros, then streams the ASCII digits, plus an optional CR LF, to the shared uart instance through its transmit/tx_byte/is_transmitting handshake. The main FSM uses it to print results in decimal instead of fixed hex templates.

Parameters:
WIDTH, 16, bit width of the input value
DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH
APPEND_CRLF, 1, when 1 send 8'h0D then 8'h0A after the last digit

Ports:
clk  input  1  system clock (100 MHz)
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; value sampled on the same edge
value  input  WIDTH  unsigned number to print
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when the last byte has finished transmitting
transmit  output  1  one-cycle pulse to uart: send tx_byte
tx_byte  output  8  byte presented to uart
is_transmitting  input  1  uart busy flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0, done=0, transmit=0, tx_byte=8'h00; BCD and shift registers cleared. Applies mid-conversion or mid-byte; the partially sent string is abandoned, and no done pulse is issued.
- States: IDLE, CONV, SKIP, LOAD, WAIT, SEND, NEXT, FIN.
- IDLE: on start=1, latch value into the shift register, clear BCD (4*DIGITS bits), clear iteration counter, go to CONV. start while busy=1 is ignored.
- CONV: exactly WIDTH cycles. Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,shift} left by 1. After WIDTH iterations go to SKIP.
- SKIP: one cycle. Digit pointer = index of the most significant nonzero nibble, or 0 (least significant) if all nibbles are zero. Value 0 therefore prints "0".
- LOAD: tx_byte <= 8'h30 + nibble[ptr], or CR/LF in the trailer phase. transmit=1 for exactly this cycle. Go to WAIT.
- WAIT: hold tx_byte; stay until is_transmitting=1, then go to SEND.
- SEND: hold tx_byte; stay until is_transmitting=0, then go to NEXT.
- NEXT: one cycle.
  - If digits remain, decrement ptr and go to LOAD.
  - If the last digit is sent and APPEND_CRLF=1, go to LOAD for 8'h0D, then 8'h0A.
  - Otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0 from the next cycle, tx_byte <= 8'h00, return to IDLE.
- Timing: start sampled at edge k; first transmit high in cycle k+WIDTH+2. At most one transmit pulse per byte. tx_byte stable from LOAD through SEND.
- A start arriving in the same cycle as done is ignored; it is accepted one cycle later.
- Widths: BCD nibbles never exceed 9 after conversion. The maximum value 2^WIDTH-1 uses all needed digits without overflow.
- No timeout: if is_transmitting never rises, the block waits indefinitely in WAIT. Only reset recovers it.

Test Plan:
- value=0, start pulse, uart model raises is_transmitting 2 cycles after transmit and holds it 20 cycles -> bytes 0x30,0x0D,0x0A; done once; first transmit at start+18.
- value=65535 -> bytes "6","5","5","3","5",0x0D,0x0A (0x36 0x35 0x35 0x33 0x35 0x0D 0x0A); exactly 7 transmit pulses.
- value=93 (0x005D), APPEND_CRLF=0 -> bytes 0x39,0x33; no leading zeros; done after second byte's is_transmitting falls.
- value=1000 -> 0x31,0x30,0x30,0x30,0x0D,0x0A (inner zeros kept); a second start pulse during transmission is ignored, and no extra bytes are sent.
- Assert reset_n=0 while in SEND of the 3rd byte of 12345 -> transmit=0, busy=0, tx_byte=0 immediately, with no done pulse. A new start with 7 after release -> 0x37,0x0D,0x0A.
- Slow uart: is_transmitting held low 50 cycles after transmit -> block stays in WAIT with tx_byte stable and no repeated transmit.
